bcd_serial_add_ctrl: RTL and testbench

- Sequencer for a multi-digit BCD add built from one 4-bit binary adder slice and the decimal-correction logic.
- The correction logic flags when the binary digit sum exceeds 9 or carries out.
- The block latches two packed BCD operands on a start request and processes one digit per clock, least-significant digit first.
- The decimal carry ripples through a registered carry flop; the result accumulates in a shift register. Sits between the operand/keypad front end and the display driver.

---
 rtl/bcd_serial_add_ctrl.sv | 98 +++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: one-digit-per-clock BCD add sequencer; define BCD_SUB_EN for ten's-complement subtract via op_sub
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4,
    parameter int CW = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
`ifdef BCD_SUB_EN
    input  logic                op_sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    localparam int W = 4*DIGITS;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state;
    logic [W-1:0] a_r, b_r, res, res_n;
    logic [CW-1:0] cnt;
    logic c, sub_r, sub_in, err_acc, corr, d_err;
    logic [3:0] a_d, b_d, b_op, dig;
    logic [4:0] z;
`ifdef BCD_SUB_EN
    assign sub_in = op_sub;
`else
    assign sub_in = 1'b0;
`endif
    // operands shift right each digit so the current digit is always in [3:0]
    always_comb begin
        a_d = a_r[3:0];
        b_d = b_r[3:0];
        b_op = sub_r ? 4'd9 - b_d : b_d;
        z = {1'b0, a_d} + {1'b0, b_op} + {4'd0, c};
        corr = z[4] | (z[3] & z[2]) | (z[3] & z[1]);
        dig = corr ? z[3:0] + 4'd6 : z[3:0];
        d_err = (a_d > 4'd9) | (b_d > 4'd9);
        res_n = (res >> 4) | (W'(dig) << (W-4));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r <= '0;
            b_r <= '0;
            res <= '0;
            cnt <= '0;
            c <= 1'b0;
            sub_r <= 1'b0;
            err_acc <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            sum <= '0;
            cout <= 1'b0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        sub_r <= sub_in;
                        c <= cin | sub_in;
                        cnt <= '0;
                        err_acc <= 1'b0;
                        busy <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_r <= a_r >> 4;
                    b_r <= b_r >> 4;
                    res <= res_n;
                    c <= corr;
                    err_acc <= err_acc | d_err;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(DIGITS-1)) begin
                        busy <= 1'b0;
                        sum <= res_n;
                        cout <= corr;
                        err <= err_acc | d_err;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: directed and random BCD add (and optional subtract) checks against a digit-arithmetic model
module tb_bcd_serial_add_ctrl;
    localparam int D = 4;
    localparam int W = 4*D;
    logic clk = 1'b0, rst, start, cin, busy, done, cout, err;
    logic [W-1:0] a, b, sum;
`ifdef BCD_SUB_EN
    logic op_sub;
`endif
    int n_vec = 0, n_bad = 0;

    bcd_serial_add_ctrl #(.DIGITS(D), .CW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef BCD_SUB_EN
        .op_sub(op_sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                  input logic sb, output logic [W-1:0] s, output logic co, output logic e);
        int cy, ai, bi, t;
        cy = sb ? 1 : int'(ci);
        s = '0;
        e = 1'b0;
        for (int i = 0; i < D; i++) begin
            ai = int'(x[4*i +: 4]);
            bi = int'(y[4*i +: 4]);
            if (ai > 9 || bi > 9) e = 1'b1;
            if (sb) bi = (9 - bi + 16) % 16;
            t = ai + bi + cy;
            s[4*i +: 4] = 4'((t >= 10) ? (t + 6) % 16 : t);
            cy = (t >= 10) ? 1 : 0;
        end
        co = cy[0];
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb,
                          input bit noisy, input logic [W-1:0] es, input logic ec, input logic ee);
        @(posedge clk); #1;
        a = x; b = y; cin = ci; start = 1'b1;
`ifdef BCD_SUB_EN
        op_sub = sb;
`endif
        @(posedge clk); #1;
        check("busy_accept", busy, 1);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef BCD_SUB_EN
        op_sub = 1'($urandom);
`endif
        start = noisy;
        for (int k = 1; k < D; k++) begin
            @(posedge clk); #1;
            check("busy_add", busy, 1);
            check("no_early_done", done, 0);
        end
        @(posedge clk); #1;
        check("busy_end", busy, 0);
        check("done_early", done, 0);
        check("sum_on_entry", sum, 32'(es));
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse", done, 1);
        check("sum", sum, 32'(es));
        check("cout", cout, 32'(ec));
        check("err", err, 32'(ee));
        @(posedge clk); #1;
        check("done_clear", done, 0);
        check("not_queued", busy, 0);
        check("sum_hold", sum, 32'(es));
    endtask

    task automatic run_rand(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        logic [W-1:0] es;
        logic ec, ee;
        model(x, y, ci, sb, es, ec, ee);
        run_op(x, y, ci, sb, 1'($urandom), es, ec, ee);
    endtask

    initial begin
        logic [W-1:0] x, y, ms;
        logic mc, me;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef BCD_SUB_EN
        op_sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        model(16'h1234, 16'h5678, 1'b0, 1'b0, ms, mc, me);
        check("model_1234", {ms, 3'b0, mc}, {16'h6912, 4'h0});
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0, 16'h6912, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0990, 16'h0010, 1'b0, 1'b0, 0, 16'h1000, 1'b0, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b1, 1'b0, 0, 16'h9999, 1'b1, 1'b0);
        model(16'h12A4, 16'h0000, 1'b0, 1'b0, ms, mc, me);
        run_op(16'h12A4, 16'h0000, 1'b0, 1'b0, 0, ms, mc, 1'b1);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0, 1'b0);
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1, 16'h3333, 1'b0, 1'b0);

        @(posedge clk); #1;
        a = 16'h4321; b = 16'h1111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        for (int k = 0; k < D + 2; k++) begin
            @(posedge clk); #1;
            check("mid_rst_no_done", done, 0);
        end
        rst = 1'b0;
        run_op(16'h0457, 16'h0368, 1'b0, 1'b0, 0, 16'h0825, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
        run_op(16'h5000, 16'h1234, 1'b0, 1'b1, 0, 16'h3766, 1'b1, 1'b0);
        run_op(16'h1234, 16'h5000, 1'b1, 1'b1, 0, 16'h6234, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < D; i++) begin
                x[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
                y[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
            end
`ifdef BCD_SUB_EN
            run_rand(x, y, 1'($urandom), 1'($urandom));
`else
            run_rand(x, y, 1'($urandom), 1'b0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
